// File: rtl/vga_text_line_scheduler.sv
// 8-glyph text line overlay: prefetches font ROM rows into a line buffer and double-buffers codes.
// Define VGA_TEXT_CURSOR_EN to add a blinking inverted cursor slot.
//
// state | meaning
// IDLE  | waiting for fetch trigger; rom_addr holds last value
// FETCH | issuing glyph row addresses for slots 0..7
// LAST  | capturing the slot 7 glyph row
module vga_text_line_scheduler #(
  parameter logic [10:0] X0           = 11'd64,
  parameter logic [10:0] Y0           = 11'd16,
  parameter logic [10:0] FETCH_COL    = 11'd600,
  parameter logic [15:0] FG_COLOR     = 16'h07E0,
  parameter logic [5:0]  BLINK_FRAMES = 6'd30
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ready_sig,
  input  logic [10:0] column_addr_sig,
  input  logic [10:0] row_addr_sig,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [2:0]  upd_idx,
  input  logic [4:0]  upd_code,
  input  logic        upd_commit,
  output logic [8:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic [2:0]  cursor_idx,
  output logic [4:0]  red_sig,
  output logic [5:0]  green_sig,
  output logic [4:0]  blue_sig
);

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;
  state_t state, state_nxt;

  logic [4:0]  shadow  [8];
  logic [4:0]  active  [8];
  logic [15:0] linebuf [8];
  logic        pending;
  logic [2:0]  k;
  logic [3:0]  g_q;
  logic        pix_on;

  logic [10:0] row_nxt;
  logic        frame_start, copy_en, trigger;
  logic [6:0]  dx;
  logic        in_win, glyph_bit, pix_val;

  assign row_nxt     = row_addr_sig + 11'd1;
  assign frame_start = ready_sig && (row_addr_sig == 11'd0) && (column_addr_sig == 11'd0);
  assign copy_en     = frame_start && (pending || upd_commit);
  assign trigger     = ready_sig && (column_addr_sig == FETCH_COL) &&
                       (row_nxt >= Y0) && (row_nxt <= Y0 + 11'd15);

  // Copy reads the pre-write shadow when a write lands on the frame-start cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending   <= 1'b0;
      upd_ready <= 1'b0;
    end else begin
      upd_ready <= 1'b1;
      if (upd_valid)
        shadow[upd_idx] <= upd_code;
      if (copy_en)
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      if (upd_commit)
        pending <= 1'b1;
      else if (frame_start)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = FETCH;
      FETCH:   if (k == 3'd7) state_nxt = LAST;
      LAST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ROM data for the address issued in cycle k arrives in cycle k+1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k        <= 3'd0;
      g_q      <= 4'd0;
      rom_addr <= 9'd0;
      for (int i = 0; i < 8; i++) linebuf[i] <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          k <= 3'd0;
          if (trigger) g_q <= row_nxt[3:0] - Y0[3:0];
        end
        FETCH: begin
          rom_addr <= {active[k], g_q};
          k        <= k + 3'd1;
          if (k != 3'd0) linebuf[k - 3'd1] <= rom_data;
        end
        LAST:    linebuf[7] <= rom_data;
        default: ;
      endcase
    end
  end

  assign dx        = column_addr_sig[6:0] - X0[6:0];
  assign in_win    = (column_addr_sig >= X0) && (column_addr_sig <= X0 + 11'd127) &&
                     (row_addr_sig >= Y0) && (row_addr_sig <= Y0 + 11'd15);
  assign glyph_bit = linebuf[dx[6:4]][4'd15 - dx[3:0]];

`ifdef VGA_TEXT_CURSOR_EN
  logic [5:0] frame_cnt;
  logic       blink;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= 6'd0;
      blink     <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == BLINK_FRAMES - 6'd1) begin
        frame_cnt <= 6'd0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  assign pix_val = (blink && (dx[6:4] == cursor_idx)) ? ~glyph_bit : glyph_bit;
`else
  logic [8:0] unused_cursor;
  assign unused_cursor = {cursor_idx, BLINK_FRAMES};
  assign pix_val       = glyph_bit;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pix_on <= 1'b0;
    else       pix_on <= in_win && pix_val;
  end

  assign {red_sig, green_sig, blue_sig} = (ready_sig && pix_on) ? FG_COLOR : 16'h0000;

endmodule
